mpadd_seq: RTL and testbench
============================

Name: mpadd_seq

Overview:
- Multi-precision add/subtract sequencer that time-multiplexes one SIZE-bit ripple-carry adder (Nbit_adder datapath) over WORDS operand words, least significant word first.
- Holds the inter-word carry in a register, handles valid/ready streaming on input and output, and reports final carry-out and signed overflow.
- Sits between an operand-fetch stream and a result sink in the arithmetic lab datapath.

Parameters:
- SIZE, 8, adder/word width in bits (>=2)
- WORDS, 4, words per operation (>=1); counter width = max(1, clog2(WORDS))

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin operation; sampled in IDLE only
- op_sub  input  1  sampled with start: 0 = A+B, 1 = A-B
- in_valid  input  1  operand word pair valid
- in_ready  output  1  block accepts operand word this cycle
- a_word  input  SIZE  operand A word
- b_word  input  SIZE  operand B word
- out_valid  output  1  result word valid
- out_ready  input  1  sink accepts result word
- sum_word  output  SIZE  result word
- out_last  output  1  marks final (most significant) result word
- busy  output  1  high in RUN and FLUSH
- done  output  1  one-cycle pulse when operation retires
- co  output  1  final carry-out (sub: 1 = no borrow); valid from done, held until next start
- ovf  output  1  signed overflow of full-width result; same validity as co

Behaviour:
- Reset (async, rst_n=0): state=IDLE, carry=0, word count=0, sub flag=0; outputs in_ready=0, out_valid=0, sum_word=0, out_last=0, busy=0, done=0, co=0, ovf=0. Reset mid-operation abandons it silently; no done.
- Datapath per accepted word: sum = a_word + (b_word XOR {SIZE{sub}}) + carry; new carry = adder carry-out. carry loaded with op_sub at start (two's-complement subtract).
- States:
  - IDLE: in_ready=0. start=1 -> latch op_sub, carry=op_sub, count=0, -> RUN. start while busy is ignored.
  - RUN: in_ready = !out_valid || out_ready (single output register, full throughput). Handshake when in_valid && in_ready: register sum into sum_word, out_valid=1, out_last=(count==WORDS-1), update carry, count++. On accepting word WORDS-1 -> FLUSH.
  - FLUSH: in_ready=0; when out_valid && out_ready -> done=1 for that cycle, -> IDLE.
- Output: out_valid cleared when out_ready && no new word loaded same cycle; sum_word/out_last stable while out_valid && !out_ready.
- Latency: word accepted in cycle n appears on sum_word in cycle n+1.
- co/ovf updated on last word accept: co = adder carry-out; ovf = (a_msb == b'_msb) && (sum_msb != a_msb), where b' is b_word after XOR.
- WORDS=1: RUN accepts one word then FLUSH.
- in_valid in IDLE/FLUSH: ignored, not consumed.

Optional Feature:
- Macro MPADD_ZFLAG_EN. Defined: extra output zero (1 bit, reset 0); set to 1 at start, ANDed with (sum==0) per accepted word; final value valid from done, held until next start. Undefined: port and logic absent.

Test Plan (SIZE=8, WORDS=4, words LSW first, out_ready=1 unless stated):
- Add 0x00FFFFFF + 0x00000001 -> result words 00,00,00,01; co=0, ovf=0; done 1 cycle after last output handshake; zero=0.
- Add 0xFFFFFFFF + 0x00000001 -> 00,00,00,00; co=1, ovf=0; zero=1 with MPADD_ZFLAG_EN.
- Sub 0x00000005 - 0x00000007 -> FE,FF,FF,FF; co=0 (borrow), ovf=0.
- Add 0x7FFFFFFF + 0x00000001 -> 00,00,00,80; ovf=1, co=0; out_last only on 0x80.
- Backpressure: out_ready=0 for 3 cycles after first word -> in_ready=0, sum_word held at first word, no word lost; final result unchanged.
- Reset pulse after 2 words accepted -> all outputs return to reset values, no done; next start runs a fresh operation correctly.

Source files
------------

// File: rtl/mpadd_seq_if.sv
// Operand/result stream bundle for mpadd_seq; the zero flag exists only when MPADD_ZFLAG_EN is defined.
interface mpadd_seq_if #(
  parameter int SIZE = 8
);
  logic            start;
  logic            op_sub;
  logic            in_valid;
  logic            in_ready;
  logic [SIZE-1:0] a_word;
  logic [SIZE-1:0] b_word;
  logic            out_valid;
  logic            out_ready;
  logic [SIZE-1:0] sum_word;
  logic            out_last;
  logic            busy;
  logic            done;
  logic            co;
  logic            ovf;
`ifdef MPADD_ZFLAG_EN
  logic            zero;
`endif

  modport master (
`ifdef MPADD_ZFLAG_EN
    input  zero,
`endif
    output start, op_sub, in_valid, a_word, b_word, out_ready,
    input  in_ready, out_valid, sum_word, out_last, busy, done, co, ovf
  );

  modport slave (
`ifdef MPADD_ZFLAG_EN
    output zero,
`endif
    input  start, op_sub, in_valid, a_word, b_word, out_ready,
    output in_ready, out_valid, sum_word, out_last, busy, done, co, ovf
  );
endinterface

// File: rtl/mpadd_seq.sv
// Word-serial multi-precision add/subtract over one SIZE-bit adder, LSW first.
// Optional MPADD_ZFLAG_EN adds a whole-result zero flag on the interface.
module mpadd_seq #(
  parameter int SIZE  = 8,
  parameter int WORDS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  mpadd_seq_if.slave bus
);
  localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t          state;
  state_t          next_state;
  logic            carry;
  logic            sub;
  logic [CW-1:0]   count;
  logic [SIZE-1:0] sum_q;
  logic            out_valid_q;
  logic            out_last_q;
  logic            done_q;
  logic            co_q;
  logic            ovf_q;
  logic            in_ready_c;
  logic            accept;
  logic            retire;
  logic            last_word;
  logic [SIZE-1:0] b_x;
  logic [SIZE-1:0] add_sum;
  logic            add_co;
  logic            add_ovf;

  // Subtraction is A + ~B + 1, the +1 coming from the carry preloaded at start.
  assign b_x              = bus.b_word ^ {SIZE{sub}};
  assign {add_co, add_sum} = {1'b0, bus.a_word} + {1'b0, b_x} + {{SIZE{1'b0}}, carry};
  assign add_ovf          = (bus.a_word[SIZE-1] == b_x[SIZE-1]) && (add_sum[SIZE-1] != bus.a_word[SIZE-1]);

  assign last_word = (count == LAST_IDX);
  assign accept    = bus.in_valid && in_ready_c;
  assign retire    = (state == FLUSH) && out_valid_q && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready_c = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) next_state = RUN;
      end
      RUN: begin
        in_ready_c = !out_valid_q || bus.out_ready;
        if (bus.in_valid && in_ready_c && last_word) next_state = FLUSH;
      end
      FLUSH: begin
        if (out_valid_q && bus.out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Single output register: a new word may replace the current one in the
  // same cycle the sink takes it, so the stream runs at one word per clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry       <= 1'b0;
      sub         <= 1'b0;
      count       <= '0;
      sum_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      co_q        <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      done_q <= retire;
      if (state == IDLE && bus.start) begin
        sub   <= bus.op_sub;
        carry <= bus.op_sub;
        count <= '0;
      end
      if (accept) begin
        sum_q       <= add_sum;
        out_valid_q <= 1'b1;
        out_last_q  <= last_word;
        carry       <= add_co;
        count       <= count + 1'b1;
        if (last_word) begin
          co_q  <= add_co;
          ovf_q <= add_ovf;
        end
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
    end
  end

`ifdef MPADD_ZFLAG_EN
  logic zero_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            zero_q <= 1'b0;
    else if (state == IDLE && bus.start)   zero_q <= 1'b1;
    else if (accept)                       zero_q <= zero_q && (add_sum == '0);
  end

  assign bus.zero = zero_q;
`endif

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.sum_word  = sum_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;
  assign bus.co        = co_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_mpadd_seq.sv
// Directed scoreboard bench for mpadd_seq (SIZE=8, WORDS=4) with a 32-bit reference model.
module tb_mpadd_seq;
  localparam int SIZE  = 8;
  localparam int WORDS = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   compared = 0;
  int   mismatched = 0;
  int   done_count = 0;

  logic [SIZE:0] sb[$];
  logic [31:0]   exp_res;
  logic          exp_co;
  logic          exp_ovf;

  mpadd_seq_if #(.SIZE(SIZE)) bus ();

  mpadd_seq #(.SIZE(SIZE), .WORDS(WORDS)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Every output handshake is matched against the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && bus.done) done_count++;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      check_output("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) check_output("out_word", {23'd0, bus.out_last, bus.sum_word}, {23'd0, sb.pop_front()});
    end
  end

  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic sub);
    logic [31:0] bx;
    logic [32:0] r;
    bx      = sub ? ~b : b;
    r       = {1'b0, a} + {1'b0, bx} + {32'd0, sub};
    exp_res = r[31:0];
    exp_co  = r[32];
    exp_ovf = (a[31] == bx[31]) && (r[31] != a[31]);
  endtask

  task automatic start_op(input logic sub);
    bus.start  = 1'b1;
    bus.op_sub = sub;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.op_sub = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] a, input logic [7:0] b, input logic [8:0] expw);
    int n;
    bus.a_word   = a;
    bus.b_word   = b;
    bus.in_valid = 1'b1;
    sb.push_back(expw);
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready || n >= 20) break;
      n++;
    end
    check_output("in_ready_wait", 32'(n < 20), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic apply_stimulus(input string tag, input logic [31:0] a, input logic [31:0] b,
                                input logic sub, input int stall);
    int cycles;
    logic [8:0] w0;
    model(a, b, sub);
    start_op(sub);
    for (int i = 0; i < WORDS; i++) begin
      send_word(a[8*i +: 8], b[8*i +: 8], {(i == WORDS - 1), exp_res[8*i +: 8]});
      if (i == 0 && stall > 0) begin
        w0 = {1'b0, exp_res[7:0]};
        bus.out_ready = 1'b0;
        bus.a_word    = a[15:8];
        bus.b_word    = b[15:8];
        bus.in_valid  = 1'b1;
        for (int s = 0; s < stall; s++) begin
          @(negedge clk);
          check_output({tag, "_stall_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
          check_output({tag, "_stall_hold"}, {22'd0, bus.out_valid, bus.out_last, bus.sum_word}, {22'd0, 1'b1, w0});
          check_output({tag, "_stall_busy"}, {31'd0, bus.busy}, 32'd1);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
      end
    end
    cycles = 0;
    forever begin
      @(negedge clk);
      cycles++;
      if (bus.done || cycles >= 20) break;
    end
    check_output({tag, "_done_latency"}, 32'(cycles), 32'd2);
    check_output({tag, "_co"}, {31'd0, bus.co}, {31'd0, exp_co});
    check_output({tag, "_ovf"}, {31'd0, bus.ovf}, {31'd0, exp_ovf});
`ifdef MPADD_ZFLAG_EN
    check_output({tag, "_zero"}, {31'd0, bus.zero}, {31'd0, (exp_res == 32'd0)});
`endif
    @(negedge clk);
    check_output({tag, "_idle"}, {30'd0, bus.busy, bus.done}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_ctl"},
                 {25'd0, bus.in_ready, bus.out_valid, bus.out_last, bus.busy, bus.done, bus.co, bus.ovf}, 32'd0);
    check_output({tag, "_sum"}, {24'd0, bus.sum_word}, 32'd0);
`ifdef MPADD_ZFLAG_EN
    check_output({tag, "_zero"}, {31'd0, bus.zero}, 32'd0);
`endif
  endtask

  initial begin
    int dc;
    bus.start     = 1'b0;
    bus.op_sub    = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a_word    = '0;
    bus.b_word    = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // in_valid in IDLE must not be consumed
    bus.in_valid = 1'b1;
    @(negedge clk);
    check_output("idle_in_ready", {30'd0, bus.in_ready, bus.out_valid}, 32'd0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;

    $display("[TB] directed operations");
    apply_stimulus("add_carry_chain", 32'h00FF_FFFF, 32'h0000_0001, 1'b0, 0);
    apply_stimulus("add_wrap_zero",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
    apply_stimulus("sub_borrow",      32'h0000_0005, 32'h0000_0007, 1'b1, 0);
    apply_stimulus("add_ovf",         32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0);
    apply_stimulus("sub_mixed",       32'h8000_0000, 32'h0000_0001, 1'b1, 0);
    apply_stimulus("backpressure",    32'h1234_56F0, 32'h0FED_CB20, 1'b0, 3);

    $display("[TB] reset mid-operation");
    dc = done_count;
    start_op(1'b0);
    send_word(8'h11, 8'h22, 9'h033);
    send_word(8'h33, 8'h44, 9'h077);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midreset");
    @(posedge clk); #1;
    sb.delete();
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_output("midreset_no_done", 32'(done_count - dc), 32'd0);
    check_output("midreset_idle", {31'd0, bus.busy}, 32'd0);
    @(posedge clk); #1;
    apply_stimulus("after_reset", 32'hA5A5_5A5A, 32'h1111_2222, 1'b1, 0);

    check_output("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
